divu_unit: RTL and testbench

//  Multi-cycle unsigned divider that executes DIVU after the control decoder selects div_op.

---
 rtl/divu_if.sv | 26 ++
 rtl/divu_unit.sv | 122 ++++++++++++
 tb/tb_divu_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/divu_if.sv
// Issue/result bundle between the execute-stage control and the DIVU unit.
// The master drives the operands and the start/cancel strobes; the slave returns status and HI/LO.
interface divu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             cancel;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             stall;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, cancel, dividend, divisor,
      input  stall, busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, cancel, dividend, divisor,
      output stall, busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/divu_unit.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle, HI = remainder, LO = quotient.
// Stalls the front end while a divide is in flight and commits HI/LO in a single done cycle.
module divu_unit #(
   parameter int WIDTH = 32
) (
   input  logic   clk,
   input  logic   rst_n,
   divu_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic [WIDTH:0]   rem_shift;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_sub;

   assign accept = bus.start & ~bus.cancel;

   // The shifted remainder carries one extra bit so the compare against d cannot overflow;
   // whichever value is kept always fits back into WIDTH bits.
   always_comb begin
      rem_shift = {r_q, q_q[WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, d_q});
      rem_sub   = rem_shift[WIDTH-1:0] - d_q;
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               q_d     = bus.dividend;
               d_d     = bus.divisor;
               r_d     = '0;
               count_d = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.cancel) begin
               state_d = S_IDLE;
            end else begin
               if (rem_ge) begin
                  r_d = rem_sub;
                  q_d = {q_q[WIDTH-2:0], 1'b1};
               end else begin
                  r_d = rem_shift[WIDTH-1:0];
                  q_d = {q_q[WIDTH-2:0], 1'b0};
               end
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Commit is unconditional here: a flush arriving now is too late to undo it.
            hi_d    = r_q;
            lo_d    = q_q;
            done_d  = 1'b1;
            dbz_d   = (d_q == '0);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   // stall releases in the DONE cycle so the next instruction issues as HI/LO land.
   assign bus.stall       = ((state_q == S_IDLE) & accept) | (state_q == S_RUN);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
endmodule

// File: tb/tb_divu_unit.sv
// Directed bench for divu_unit: expected HI/LO/div_by_zero are queued at issue and
// compared whenever the unit pulses done.
module tb_divu_unit;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dbz;
   } exp_t;

   logic clk;
   logic rst_n;
   divu_if #(.WIDTH(W)) bus ();

   divu_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.lo  = '1;
         e.hi  = a;
         e.dbz = 1'b1;
      end else begin
         e.lo  = a / b;
         e.hi  = a % b;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every done must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         exp_t e;
         exp_t o;
         done_cnt++;
         checks++;
         assert (sb.size() != 0)
         else begin
            errors++;
            $error("FAIL unexpected_done: observed lo=0x%0h hi=0x%0h required no done",
                   bus.lo, bus.hi);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            o = '{lo: bus.lo, hi: bus.hi, dbz: bus.div_by_zero};
            checks++;
            assert (o === e)
            else begin
               errors++;
               $error("FAIL result: observed lo=0x%0h hi=0x%0h dbz=%0b expected lo=0x%0h hi=0x%0h dbz=%0b",
                      o.lo, o.hi, o.dbz, e.lo, e.hi, e.dbz);
            end
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      if (push) sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int c0;
      int n;
      c0 = done_cnt;
      n  = 0;
      while (done_cnt == c0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk({tag, "_timeout"}, 64'(done_cnt != c0), 64'd1);
   endtask

   initial begin
      int stall_cnt;
      int done_cycle;
      int d0;

      bus.start    = 1'b0;
      bus.cancel   = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  64'(bus.busy),        64'd0);
      chk("rst_stall", 64'(bus.stall),       64'd0);
      chk("rst_done",  64'(bus.done),        64'd0);
      chk("rst_dbz",   64'(bus.div_by_zero), 64'd0);
      chk("rst_hi",    64'(bus.hi),          64'd0);
      chk("rst_lo",    64'(bus.lo),          64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 100 / 7 with cycle-accurate stall and done timing
      stall_cnt  = 0;
      done_cycle = -1;
      bus.start    = 1'b1;
      bus.dividend = 32'd100;
      bus.divisor  = 32'd7;
      sb.push_back(model(32'd100, 32'd7));
      #1;
      if (bus.stall) stall_cnt++;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = 32'hFFFF_0000;
      bus.divisor  = 32'd1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.stall) stall_cnt++;
         if (bus.done && done_cycle < 0) done_cycle = c;
      end
      chk("t1_stall_cycles", 64'(stall_cnt),  64'(W + 1));
      chk("t1_done_cycle",   64'(done_cycle), 64'(W + 2));
      chk("t1_lo", 64'(bus.lo), 64'd14);
      chk("t1_hi", 64'(bus.hi), 64'd2);

      // start together with cancel in IDLE is dropped
      @(negedge clk);
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      #1;
      chk("idle_cancel_stall", 64'(bus.stall), 64'd0);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      chk("idle_cancel_busy", 64'(bus.busy), 64'd0);

      // extremes
      issue(32'hFFFF_FFFF, 32'd1, 1'b1);
      wait_done("t2a", 60);
      issue(32'h1234_5678, 32'h1234_5679, 1'b1);
      wait_done("t2b", 60);

      // divide by zero
      issue(32'hDEAD_BEEF, 32'd0, 1'b1);
      wait_done("t3", 60);
      chk("t3_dbz_after", 64'(bus.div_by_zero), 64'd0);

      // start while running is ignored
      d0 = done_cnt;
      issue(32'd50, 32'd5, 1'b1);
      repeat (9) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd9;
      bus.divisor  = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("t4", 60);
      repeat (45) @(negedge clk);
      chk("t4_single_done", 64'(done_cnt - d0), 64'd1);
      chk("t4_idle", 64'(bus.busy), 64'd0);

      // cancel mid-run: no commit
      d0 = done_cnt;
      issue(32'd1000, 32'd3, 1'b0);
      repeat (4) @(negedge clk);
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      chk("t5_busy_after_cancel",  64'(bus.busy),  64'd0);
      chk("t5_stall_after_cancel", 64'(bus.stall), 64'd0);
      repeat (40) @(negedge clk);
      chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t5_lo_kept", 64'(bus.lo), 64'd10);
      chk("t5_hi_kept", 64'(bus.hi), 64'd0);

      // asynchronous reset mid-divide
      d0 = done_cnt;
      issue(32'd77, 32'd4, 1'b0);
      repeat (19) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_busy",  64'(bus.busy),  64'd0);
      chk("t6_stall", 64'(bus.stall), 64'd0);
      chk("t6_hi",    64'(bus.hi),    64'd0);
      chk("t6_lo",    64'(bus.lo),    64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
      issue(32'd77, 32'd4, 1'b1);
      wait_done("t6_rerun", 60);
      chk("t6_lo_rerun", 64'(bus.lo), 64'd19);
      chk("t6_hi_rerun", 64'(bus.hi), 64'd1);

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
